// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared FSM state type and default parameters for the DAC serial controller
// Contents:
//   dac_state_t    FSM states IDLE/SHIFT/HOLD/GAP
//   DEF_*          default DATA_W, HALF_DIV, GAP_CYC
//   HOLD_CYC       fixed length of the post-shift HOLD phase
//   frame_cycles() word period in clk_X4 cycles for a given parameter set
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_t;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_HALF_DIV = 2;
    localparam int DEF_GAP_CYC  = 150;
    localparam int HOLD_CYC     = 2;

    function automatic int frame_cycles(int data_w, int half_div, int gap_cyc);
        return data_w * 2 * half_div + HOLD_CYC + gap_cyc;
    endfunction

endpackage

// File: rtl/dac_serial_ctrl_if.sv
// rtl/dac_serial_ctrl_if.sv - sample hand-off interface into the DAC serial controller
// Signals:
//   s_valid  producer offers a sample
//   s_data   sample word, DATA_W bits
//   s_ready  controller accepts the sample this cycle
// Modports: master (sample producer), slave (dac_serial_ctrl)
interface dac_serial_ctrl_if
    import dac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/dac_clk_div.sv
// rtl/dac_clk_div.sv - HALF_DIV phase counter producing a half-period tick
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   clear  restart the phase count from zero on the next edge
//   tick   high on the last cycle of each sclk half-period
module dac_clk_div
    import dac_pkg::*;
#(
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    // The count returns to zero on the tick compare, never by rolling over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dac_serial_ctrl.sv
// rtl/dac_serial_ctrl.sv - serial DAC word transmitter with load strobe and repeat mode
// Ports:
//   clk_X4       single clock, all state changes on its rising edge
//   rst          asynchronous active-high reset
//   enable       high = run, low = abort to IDLE
//   repeat_mode  re-send the held sample when no new sample is offered
//   s_if         sample hand-off (s_valid / s_data / s_ready)
//   sclk, sdi    serial clock and data to the DAC (data MSB first, sampled on sclk rise)
//   ld           load strobe, high through SHIFT and HOLD
//   busy         a transfer is in progress
//   done         one-cycle pulse on the final GAP cycle
module dac_serial_ctrl
    import dac_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HALF_DIV = DEF_HALF_DIV,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic         clk_X4,
    input  logic         rst,
    input  logic         enable,
    input  logic         repeat_mode,
    dac_serial_ctrl_if.slave s_if,
    output logic         sclk,
    output logic         sdi,
    output logic         ld,
    output logic         busy,
    output logic         done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = $clog2((GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    dac_state_t        state, state_n;
    logic              phase, phase_n;        // 0 = sclk low half, 1 = sclk high half
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [CW-1:0]     cyc_cnt, cyc_n;        // shared by HOLD and GAP
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] hold_reg, hold_n;
    logic              have_sample, have_n;

    logic sclk_n, sdi_n, ld_n, busy_n, done_n;
    logic tick;
    logic s_ready;
    logic accept;
    logic repeat_start;

    assign s_ready      = (state == ST_IDLE) && enable && !rst;
    assign s_if.s_ready = s_ready;
    assign accept       = s_if.s_valid && s_ready;
    assign repeat_start = (state == ST_IDLE) && enable && repeat_mode
                          && have_sample && !s_if.s_valid;

    dac_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk   (clk_X4),
        .rst   (rst),
        .clear ((state != ST_SHIFT) || !enable),
        .tick  (tick)
    );

    always_ff @(posedge clk_X4 or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            bit_cnt     <= '0;
            cyc_cnt     <= '0;
            shreg       <= '0;
            hold_reg    <= '0;
            have_sample <= 1'b0;
            sclk        <= 1'b1;
            sdi         <= 1'b0;
            ld          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            bit_cnt     <= bit_n;
            cyc_cnt     <= cyc_n;
            shreg       <= shreg_n;
            hold_reg    <= hold_n;
            have_sample <= have_n;
            sclk        <= sclk_n;
            sdi         <= sdi_n;
            ld          <= ld_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next state and counters. Outputs are decoded from the next position
    // and registered, so each output flop matches the cycle it labels.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_cnt;
        cyc_n   = cyc_cnt;
        shreg_n = shreg;
        hold_n  = hold_reg;
        have_n  = have_sample;

        if (!enable) begin
            // Abort: the held sample survives, the transfer does not.
            state_n = ST_IDLE;
            phase_n = 1'b0;
            bit_n   = '0;
            cyc_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold_n  = s_if.s_data;
                        have_n  = 1'b1;
                        shreg_n = s_if.s_data;
                        state_n = ST_SHIFT;
                        phase_n = 1'b0;
                        bit_n   = '0;
                    end else if (repeat_start) begin
                        shreg_n = hold_reg;
                        state_n = ST_SHIFT;
                        phase_n = 1'b0;
                        bit_n   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            phase_n = 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            state_n = ST_HOLD;
                            phase_n = 1'b0;
                            bit_n   = '0;
                            cyc_n   = '0;
                        end else begin
                            // New bit appears as sclk falls, keeping sdi stable around the rise.
                            phase_n = 1'b0;
                            bit_n   = bit_cnt + 1'b1;
                            shreg_n = shreg << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        state_n = ST_GAP;
                        cyc_n   = '0;
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        state_n = ST_IDLE;
                        cyc_n   = '0;
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        sclk_n = (state_n == ST_SHIFT) ? phase_n : 1'b1;
        sdi_n  = (state_n == ST_SHIFT) && shreg_n[DATA_W-1];
        ld_n   = (state_n == ST_SHIFT) || (state_n == ST_HOLD);
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_GAP) && (cyc_n == GAP_LAST);
    end

endmodule

// File: tb/tb_dac_serial_ctrl.sv
// tb/tb_dac_serial_ctrl.sv - self-checking bench for dac_serial_ctrl
`timescale 1ns/1ps
module tb_dac_serial_ctrl;

    localparam int P_A = 200;

    logic clk = 1'b0;
    logic rst;
    logic en_a, rep_a, en_b, rep_b;
    logic sclk_a, sdi_a, ld_a, busy_a, done_a;
    logic sclk_b, sdi_b, ld_b, busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dac_serial_ctrl_if #(.DATA_W(12)) a_if ();
    dac_serial_ctrl_if #(.DATA_W(16)) b_if ();

    dac_serial_ctrl dut_a (
        .clk_X4      (clk),
        .rst         (rst),
        .enable      (en_a),
        .repeat_mode (rep_a),
        .s_if        (a_if),
        .sclk        (sclk_a),
        .sdi         (sdi_a),
        .ld          (ld_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    dac_serial_ctrl #(.DATA_W(16), .HALF_DIV(1), .GAP_CYC(1)) dut_b (
        .clk_X4      (clk),
        .rst         (rst),
        .enable      (en_b),
        .repeat_mode (rep_b),
        .s_if        (b_if),
        .sclk        (sclk_b),
        .sdi         (sdi_b),
        .ld          (ld_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    // Reference: a frame is a list of cycle offsets 1..P, each offset's
    // outputs follow directly from the bit timing arithmetic.
    // Returns {sclk, sdi, ld, busy, done}.
    function automatic logic [4:0] frame_out(int dw, int hd, int gc, logic [31:0] w, int i);
        int sh;
        int b;
        logic hi;
        sh = dw * 2 * hd;
        if (i <= sh) begin
            b  = (i - 1) / (2 * hd);
            hi = (((i - 1) % (2 * hd)) >= hd);
            return {hi, w[dw-1-b], 1'b1, 1'b1, 1'b0};
        end else if (i <= sh + 2) begin
            return 5'b10110;
        end
        return {1'b1, 1'b0, 1'b0, 1'b1, (i == sh + 2 + gc)};
    endfunction

    // Behavioural model of DUT A
    bit          m_in;
    int          m_off;
    logic [11:0] m_word, m_held;
    bit          m_have;
    bit          m_acc;

    task automatic model_reset();
        m_in = 0; m_off = 0; m_word = '0; m_held = '0; m_have = 0; m_acc = 0;
    endtask

    task automatic model_step();
        m_acc = 0;
        if (!m_in) begin
            if (en_a && a_if.s_valid) begin
                m_held = a_if.s_data; m_have = 1; m_word = a_if.s_data;
                m_in = 1; m_off = 1; m_acc = 1;
            end else if (en_a && rep_a && m_have) begin
                m_word = m_held; m_in = 1; m_off = 1;
            end
        end else if (!en_a || m_off == P_A) begin
            m_in = 0;
        end else begin
            m_off++;
        end
    endtask

    function automatic logic [5:0] model_exp();
        if (m_in) return {1'b0, frame_out(12, 2, 150, {20'd0, m_word}, m_off)};
        return {en_a && !rst, 5'b10000};
    endfunction

    function automatic logic [5:0] act_a();
        return {a_if.s_ready, sclk_a, sdi_a, ld_a, busy_a, done_a};
    endfunction

    function automatic logic [5:0] act_b();
        return {b_if.s_ready, sclk_b, sdi_b, ld_b, busy_b, done_b};
    endfunction

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b {rdy,sclk,sdi,ld,busy,done} at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observed-side bookkeeping for DUT A
    int          n_done;
    int          n_rise;
    logic [31:0] cap;
    logic        prev_sclk;

    task automatic obs_clear();
        n_done = 0; n_rise = 0; cap = '0;
    endtask

    task automatic cyc(string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, act_a(), model_exp());
        if (done_a) n_done++;
        if (sclk_a && !prev_sclk) begin
            cap = {cap[30:0], sdi_a};
            n_rise++;
        end
        prev_sclk = sclk_a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_a = 0; rep_a = 0; en_b = 0; rep_b = 0;
        a_if.s_valid = 0; a_if.s_data = '0;
        b_if.s_valid = 0; b_if.s_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prev_sclk = 1'b1;
        obs_clear();
    endtask

    typedef struct {
        logic [11:0] word;
        int          cyc;
        logic [5:0]  exp;    // {rdy, sclk, sdi, ld, busy, done}
    } vec_t;

    vec_t vecs[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{12'h400, 1,   6'b000110};
        vecs[1]  = '{12'h400, 3,   6'b010110};
        vecs[2]  = '{12'h400, 5,   6'b001110};
        vecs[3]  = '{12'h400, 8,   6'b011110};
        vecs[4]  = '{12'h400, 9,   6'b000110};
        vecs[5]  = '{12'h400, 48,  6'b010110};
        vecs[6]  = '{12'h400, 49,  6'b010110};
        vecs[7]  = '{12'h400, 50,  6'b010110};
        vecs[8]  = '{12'h400, 51,  6'b010010};
        vecs[9]  = '{12'h400, 199, 6'b010010};
        vecs[10] = '{12'h400, 200, 6'b010011};
        vecs[11] = '{12'h400, 201, 6'b110000};
        vecs[12] = '{12'hABC, 1,   6'b001110};
        vecs[13] = '{12'hABC, 7,   6'b010110};
        vecs[14] = '{12'hABC, 29,  6'b001110};
        vecs[15] = '{12'hABC, 41,  6'b000110};

        // Reset state, sampled while rst is still high
        rst = 1'b1;
        en_a = 1; rep_a = 0; en_b = 1; rep_b = 0;
        a_if.s_valid = 0; a_if.s_data = '0;
        b_if.s_valid = 0; b_if.s_data = '0;
        #12;
        check("reset_a", act_a(), 6'b010000);
        check("reset_b", act_b(), 6'b010000);

        // Table: single-sample frames checked at fixed cycle offsets
        foreach (vecs[v]) begin
            do_reset();
            en_a = 1;
            a_if.s_valid = 1; a_if.s_data = vecs[v].word;
            for (int k = 1; k <= vecs[v].cyc; k++) begin
                @(posedge clk);
                #1;
                a_if.s_valid = 0;
            end
            check($sformatf("vec%0d_cyc%0d", v, vecs[v].cyc), act_a(), vecs[v].exp);
        end

        // Single 12'h400 frame against the model: 12 rises, one done, word captured
        do_reset();
        en_a = 1;
        a_if.s_valid = 1; a_if.s_data = 12'h400;
        cyc("single");
        a_if.s_valid = 0;
        for (int i = 0; i < P_A + 3; i++) cyc("single");
        check_val("single_rises", n_rise, 12);
        check_val("single_done", n_done, 1);
        check_val("single_word", int'(cap[11:0]), 12'h400);

        // Repeat mode, then a new sample offered during the second frame's GAP
        do_reset();
        en_a = 1; rep_a = 1;
        a_if.s_valid = 1; a_if.s_data = 12'hABC;
        cyc("repeat");
        a_if.s_valid = 0;
        for (int i = 0; i < 300; i++) cyc("repeat");
        check_val("repeat_frames", n_done, 1);
        a_if.s_valid = 1; a_if.s_data = 12'h123;
        begin
            bit got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                cyc("repeat_new");
                if (m_acc) begin
                    got = 1;
                    a_if.s_valid = 0;
                end
            end
            check_val("repeat_accept", int'(got), 1);
        end
        obs_clear();
        for (int i = 0; i < P_A; i++) cyc("frame3");
        check_val("frame3_word", int'(cap[11:0]), 12'h123);
        check_val("frame3_done", n_done, 1);
        rep_a = 0;
        for (int i = 0; i < 3; i++) cyc("frame3_tail");

        // Abort in SHIFT at bit 5, then re-enable with repeat
        do_reset();
        en_a = 1;
        a_if.s_valid = 1; a_if.s_data = 12'h5A5;
        cyc("abort");
        a_if.s_valid = 0;
        for (int i = 0; i < 20; i++) cyc("abort");
        en_a = 0;
        cyc("abort_drop");
        check("abort_idle", act_a(), 6'b010000);
        for (int i = 0; i < 5; i++) cyc("abort_off");
        check_val("abort_no_done", n_done, 0);
        en_a = 1; rep_a = 1;
        obs_clear();
        for (int i = 0; i < P_A + 1; i++) cyc("reenable");
        rep_a = 0;
        cyc("reenable");
        check_val("reenable_word", int'(cap[11:0]), 12'h5A5);
        check_val("reenable_rises", n_rise, 12);
        check_val("reenable_done", n_done, 1);

        // Asynchronous reset in GAP; afterwards no repeat because nothing is held
        do_reset();
        en_a = 1; rep_a = 1;
        a_if.s_valid = 1; a_if.s_data = 12'hFFF;
        cyc("rst_gap");
        a_if.s_valid = 0;
        for (int i = 0; i < 99; i++) cyc("rst_gap");
        rst = 1'b1;
        #2;
        check("async_rst", act_a(), 6'b010000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_clear();
        for (int i = 0; i < 60; i++) cyc("after_rst");
        check_val("after_rst_done", n_done, 0);
        check_val("after_rst_busy", int'(busy_a), 0);

        // Second configuration: 16-bit word, HALF_DIV=1, GAP_CYC=1
        do_reset();
        en_b = 1;
        b_if.s_valid = 1; b_if.s_data = 16'h8001;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clk);
            #1;
            b_if.s_valid = 0;
            if (i <= 35) check($sformatf("cfgb_cyc%0d", i), act_b(), {1'b0, frame_out(16, 1, 1, 32'h8001, i)});
            else         check("cfgb_idle", act_b(), 6'b110000);
        end
        en_b = 0;

        // s_valid held high with changing data: one accept per frame
        do_reset();
        en_a = 1;
        a_if.s_valid = 1;
        begin
            int n_acc = 0;
            for (int i = 0; i < 4 * (P_A + 1); i++) begin
                a_if.s_data = 12'($urandom);
                cyc("stream");
                if (m_acc) n_acc++;
            end
            check_val("stream_accepts", n_acc, 4);
            check_val("stream_dones", n_done, 4);
        end

        // Random enable / repeat / valid traffic against the model
        do_reset();
        en_a = 1;
        for (int i = 0; i < 4000; i++) begin
            en_a = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) == 0) rep_a = ~rep_a;
            a_if.s_valid = ($urandom_range(0, 199) == 0) ? 1'b1 : (a_if.s_valid && !m_acc && $urandom_range(0, 3) != 0);
            a_if.s_data = 12'($urandom);
            cyc("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
